// File: rtl/fp_cmp_minmax_seq_if.sv
// -----------------------------------------------------------------------------
// fp_cmp_minmax_seq_if
//   Bundle of the streaming min/max reducer's control, input-stream and
//   result-stream signals.
//
//   master : producer / consumer side (drives elements, abort, out_ready)
//   slave  : the reducer itself
//
//   abort          synchronous packet discard
//   in_valid       input element valid
//   in_ready       reducer can take an element
//   in_data        FP element (sig_width+exp_width+1 bits)
//   in_last        element is the last of its packet
//   out_valid      result valid
//   out_ready      result consumed
//   out_min/max    packet min and max
//   out_min_idx    zero-based index of the min
//   out_max_idx    zero-based index of the max
//   out_count      element count, saturating
//   out_unordered  some comparison in the packet was unordered
//   busy           a packet is in flight or a result is pending
// -----------------------------------------------------------------------------
interface fp_cmp_minmax_seq_if #(
    parameter int sig_width = 23,
    parameter int exp_width = 8,
    parameter int idx_width = 16
);
    localparam int W = sig_width + exp_width + 1;

    logic                 abort;
    logic                 in_valid;
    logic                 in_ready;
    logic [W-1:0]         in_data;
    logic                 in_last;
    logic                 out_valid;
    logic                 out_ready;
    logic [W-1:0]         out_min;
    logic [W-1:0]         out_max;
    logic [idx_width-1:0] out_min_idx;
    logic [idx_width-1:0] out_max_idx;
    logic [idx_width-1:0] out_count;
    logic                 out_unordered;
    logic                 busy;

    modport master (
        output abort, in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_min, out_max, out_min_idx,
               out_max_idx, out_count, out_unordered, busy
    );

    modport slave (
        input  abort, in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_min, out_max, out_min_idx,
               out_max_idx, out_count, out_unordered, busy
    );
endinterface

// File: rtl/fp_cmp_minmax_seq.sv
// -----------------------------------------------------------------------------
// fp_cmp_minmax_seq
//   Streaming min/max reducer. One floating-point comparator is shared in time
//   between the running-max check (CMP_MAX) and the running-min check
//   (CMP_MIN); steady-state throughput is one element per three cycles.
//   At end of packet it presents min, max, their indices, the saturating
//   element count and a sticky unordered flag.
//
//   Ports
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    fp_cmp_minmax_seq_if.slave (handshakes, data, results, busy)
//
//   fp_cmp_minmax_seq_cmp carries the compare semantics of DW_fp_cmp with
//   zctr=0 (only the altb/agtb/unordered flags are consumed here); its port
//   and parameter names match, so it maps one-to-one onto the library part.
// -----------------------------------------------------------------------------

module fp_cmp_minmax_seq_cmp #(
    parameter int sig_width       = 23,
    parameter int exp_width       = 8,
    parameter int ieee_compliance = 0
) (
    input  logic [sig_width+exp_width:0] a,
    input  logic [sig_width+exp_width:0] b,
    output logic                         altb,
    output logic                         agtb,
    output logic                         unordered
);
    localparam int W = sig_width + exp_width + 1;

    // Without IEEE compliance, denormals collapse to zero and every value with
    // an all-ones exponent behaves as infinity; NaN never appears.
    function automatic logic [W-2:0] magnitude(input logic [W-2:0] m);
        logic [exp_width-1:0] e;
        e = m[W-2:sig_width];
        if (ieee_compliance != 0) return m;
        if (e == '0)              return '0;
        if (e == '1)              return {e, {sig_width{1'b0}}};
        return m;
    endfunction

    function automatic logic is_nan(input logic [W-2:0] m);
        return (ieee_compliance != 0) && (m[W-2:sig_width] == '1) &&
               (m[sig_width-1:0] != '0);
    endfunction

    logic [W-2:0] mag_a;
    logic [W-2:0] mag_b;

    // NOTE: every always_comb output gets a default before any branch, so no
    // path leaves a value unassigned and no latch is inferred.
    always_comb begin
        mag_a     = magnitude(a[W-2:0]);
        mag_b     = magnitude(b[W-2:0]);
        altb      = 1'b0;
        agtb      = 1'b0;
        unordered = 1'b0;
        if (is_nan(a[W-2:0]) || is_nan(b[W-2:0])) begin
            unordered = 1'b1;
        end else if (!((mag_a == '0) && (mag_b == '0))) begin
            // Both zero (either sign) is equality; otherwise sign decides,
            // then magnitude with the sense flipped for negatives.
            if (a[W-1] != b[W-1]) begin
                if (a[W-1]) altb = 1'b1;
                else        agtb = 1'b1;
            end else if (mag_a != mag_b) begin
                if ((mag_a > mag_b) != a[W-1]) agtb = 1'b1;
                else                           altb = 1'b1;
            end
        end
    end
endmodule

module fp_cmp_minmax_seq #(
    parameter int sig_width       = 23,
    parameter int exp_width       = 8,
    parameter int ieee_compliance = 0,
    parameter int idx_width       = 16
) (
    input logic                clk,
    input logic                rst_n,
    fp_cmp_minmax_seq_if.slave bus
);
    localparam int W = sig_width + exp_width + 1;

    typedef enum logic [1:0] {
        ACCEPT,
        CMP_MAX,
        CMP_MIN,
        DONE
    } state_t;

    state_t               state_q;
    logic                 first_q;
    logic [W-1:0]         min_q;
    logic [W-1:0]         max_q;
    logic [idx_width-1:0] min_idx_q;
    logic [idx_width-1:0] max_idx_q;
    logic [idx_width-1:0] count_q;
    logic [W-1:0]         hold_q;
    logic                 hold_last_q;
    logic [idx_width-1:0] hold_idx_q;
    logic                 unord_q;
    logic                 out_valid_q;
    logic                 busy_q;

    logic [idx_width-1:0] count_d;
    logic [W-1:0]         cmp_b;
    logic                 altb;
    logic                 agtb;
    logic                 unordered;

    // The comparator's 'a' is always the held element; 'b' switches between
    // the running max and the running min depending on the compare phase.
    assign cmp_b = (state_q == CMP_MIN) ? min_q : max_q;

    fp_cmp_minmax_seq_cmp #(
        .sig_width      (sig_width),
        .exp_width      (exp_width),
        .ieee_compliance(ieee_compliance)
    ) u_cmp (
        .a        (hold_q),
        .b        (cmp_b),
        .altb     (altb),
        .agtb     (agtb),
        .unordered(unordered)
    );

    // Count saturates at all-ones; indices past that point read the saturated
    // value because hold_idx is sampled from the count.
    assign count_d = (&count_q) ? count_q : count_q + 1'b1;

    // Abort masks in_ready so a same-cycle element is never taken.
    assign bus.in_ready      = (state_q == ACCEPT) && !bus.abort;
    assign bus.out_valid     = out_valid_q;
    assign bus.out_min       = min_q;
    assign bus.out_max       = max_q;
    assign bus.out_min_idx   = min_idx_q;
    assign bus.out_max_idx   = max_idx_q;
    assign bus.out_count     = count_q;
    assign bus.out_unordered = unord_q;
    assign bus.busy          = busy_q;

    // NOTE: data registers are reset along with control, because the result
    // outputs are required to read zero after reset and must never expose a
    // partial packet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ACCEPT;
            first_q     <= 1'b1;
            min_q       <= '0;
            max_q       <= '0;
            min_idx_q   <= '0;
            max_idx_q   <= '0;
            count_q     <= '0;
            hold_q      <= '0;
            hold_last_q <= 1'b0;
            hold_idx_q  <= '0;
            unord_q     <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else if (bus.abort) begin
            // NOTE: sequential state uses non-blocking assignments only, so
            // every register samples pre-edge values regardless of order.
            state_q     <= ACCEPT;
            first_q     <= 1'b1;
            count_q     <= '0;
            unord_q     <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            unique case (state_q)
                ACCEPT: begin
                    if (bus.in_valid) begin
                        busy_q <= 1'b1;
                        if (first_q) begin
                            min_q     <= bus.in_data;
                            max_q     <= bus.in_data;
                            min_idx_q <= '0;
                            max_idx_q <= '0;
                            count_q   <= idx_width'(1);
                            unord_q   <= 1'b0;
                            first_q   <= 1'b0;
                            if (bus.in_last) begin
                                state_q     <= DONE;
                                out_valid_q <= 1'b1;
                            end
                        end else begin
                            hold_q      <= bus.in_data;
                            hold_last_q <= bus.in_last;
                            hold_idx_q  <= count_q;
                            count_q     <= count_d;
                            state_q     <= CMP_MAX;
                        end
                    end
                end
                CMP_MAX: begin
                    // Ties and unordered results leave the max untouched, so
                    // the earliest occurrence keeps its index.
                    if (unordered) begin
                        unord_q <= 1'b1;
                    end else if (agtb) begin
                        max_q     <= hold_q;
                        max_idx_q <= hold_idx_q;
                    end
                    state_q <= CMP_MIN;
                end
                CMP_MIN: begin
                    if (unordered) begin
                        unord_q <= 1'b1;
                    end else if (altb) begin
                        min_q     <= hold_q;
                        min_idx_q <= hold_idx_q;
                    end
                    if (hold_last_q) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end else begin
                        state_q <= ACCEPT;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_q     <= ACCEPT;
                        first_q     <= 1'b1;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                default: state_q <= ACCEPT;
            endcase
        end
    end
endmodule

// File: doc/fp_cmp_minmax_seq.md
# fp_cmp_minmax_seq

Streaming min/max reducer built around a single shared `DW_fp_cmp` instance. It accepts a packet of IEEE floating-point values over a valid/ready handshake and time-multiplexes the one comparator between the running-max and running-min checks. At end of packet it presents the min, the max, their element indices, the element count and a sticky unordered flag. It sits between an FP datapath producer and downstream statistics/threshold logic.

## Interface
- `sig_width`, 23, significand width passed to `DW_fp_cmp`
- `exp_width`, 8, exponent width passed to `DW_fp_cmp`
- `ieee_compliance`, 0, passed to `DW_fp_cmp`; NaN/unordered detection is only meaningful when set to 1
- `idx_width`, 16, width of the index and count fields
- `clk`  in  1  the single clock; all state updates on its rising edge
- `rst_n`  in  1  reset, asynchronous and active-low
- `abort`  in  1  synchronous packet discard
- `in_valid`  in  1  input element valid
- `in_ready`  out  1  block can take an element
- `in_data`  in  `sig_width+exp_width+1`  FP element
- `in_last`  in  1  element is the last of its packet
- `out_valid`  out  1  result valid
- `out_ready`  in  1  result consumed
- `out_min`, `out_max`  out  `sig_width+exp_width+1` each  packet min and max
- `out_min_idx`, `out_max_idx`  out  `idx_width` each  index of min and of max, zero-based
- `out_count`  out  `idx_width`  elements in the packet, saturating
- `out_unordered`  out  1  at least one comparison in the packet returned `unordered`
- `busy`  out  1  state is not ACCEPT, or a packet is partially accumulated

## Operation
- The block has one `DW_fp_cmp` instance with `zctr`=0.
  - Its `a` input is always `hold`.
  - Its `b` input is the running max in CMP_MAX and the running min in CMP_MIN.
  - The `z0`, `z1` and status outputs are unused.
- FSM states are ACCEPT, CMP_MAX, CMP_MIN and DONE. Reset puts the FSM in ACCEPT with `first`=1.
- ACCEPT:
  - `in_ready`=1.
  - On an `in_valid` handshake with `first`=1:
    - load min and max with `in_data`, and both indices with 0;
    - set count to 1 and `first` to 0.
    - Next state is DONE if `in_last`=1, otherwise ACCEPT.
  - On an `in_valid` handshake with `first`=0:
    - latch `in_data` into `hold`, `in_last` into `hold_last`, and count into `hold_idx`;
    - increment count, saturating at all-ones;
    - go to CMP_MAX.
- CMP_MAX (`in_ready`=0): if `agtb`, set max to `hold` and `max_idx` to `hold_idx`. Then go to CMP_MIN.
- CMP_MIN (`in_ready`=0): if `altb`, set min to `hold` and `min_idx` to `hold_idx`. Then go to DONE if `hold_last`, otherwise ACCEPT.
- Ties (`aeqb`) never update, so the first occurrence wins. -0 and +0 compare equal.
- `unordered` from the comparator in either CMP state:
  - suppresses the update for that state;
  - sets the sticky unordered flag.
- DONE:
  - `out_valid`=1 and `in_ready`=0.
  - On `out_valid && out_ready`, go to ACCEPT and set `first`=1.
  - The unordered flag and count are cleared on entry to the next packet's first element.
- `abort`=1 in any state:
  - next state is ACCEPT with `first`=1;
  - the unordered flag and count are cleared;
  - any same-cycle input handshake is ignored, because `in_ready` is forced to 0 while `abort`=1.
- Count saturation: indices of elements beyond the saturation point equal the saturated value.

## Timing
- Reset values:
  - `in_ready`=1 once `rst_n` is released;
  - `out_valid`=0 and `busy`=0;
  - all data, index and count outputs are 0;
  - `out_unordered`=0.
- All outputs are registered, except that `in_ready` is decoded from the state register and `abort`.
- Throughput is one element per 3 cycles in steady state (ACCEPT, CMP_MAX, CMP_MIN).
- Latency, with the last element handshaked in cycle T:
  - multi-element packet: `out_valid` rises at T+3;
  - single-element packet: `out_valid` rises at T+1.
- Result outputs stay stable while `out_valid`=1 and `out_ready`=0.
- The first element of the next packet can be accepted one cycle after the out handshake.
- `rst_n` asserted mid-packet immediately zeroes all state and outputs; no partial result is ever emitted.

## Test plan
- Packet [0x3F800000 (1.0), 0xC0000000 (-2.0), 0x40600000 (3.5), 0x3F000000 (0.5), last] -> `out_min`=0xC0000000, `out_min_idx`=1, `out_max`=0x40600000, `out_max_idx`=2, `out_count`=4, `out_unordered`=0, with `out_valid` 3 cycles after the last handshake.
- Ties [0x40000000, 0x40000000, 0x80000000, 0x00000000, last] -> max idx 0, min=0x80000000 at idx 2 (zero tie keeps the earlier element), count=4.
- With `ieee_compliance`=1, packet [1.0, 0x7FC00000 (NaN), 0.5, last] -> `out_unordered`=1, min=0.5 idx 2, max=1.0 idx 0.
- Single element 0x3F800000 with `in_last` -> `out_valid` 1 cycle later, min=max=1.0, both idx 0, count 1.
- Backpressure:
  - hold `out_ready`=0 for 10 cycles -> outputs stable and `in_ready`=0 throughout;
  - on release, the next packet is accepted the cycle after the handshake.
- Abort and reset:
  - `abort` pulsed during CMP_MIN of a 3-element packet, then a fresh packet [2.0, last] -> result min=max=2.0 and count 1;
  - `rst_n` pulsed mid-packet -> all outputs 0 and `in_ready`=1 once `rst_n` is released.
